// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin sequencer for the 3-bit select of the 4:1 channel mux
// Ports: clk_i clock; rst_ni async active-low reset; en_i scan enable (low parks);
//   ch_mask_i channel enables (bit0 = CH_IN1); dc_req_i select DC level instead of scanning;
//   dwell_i valid cycles per channel (0 acts as 1); sel_o mux select (0-3 channel, 4 DC, 7 zero);
//   sel_valid_o mux output settled; ch_id_o selected channel; frame_done_o end-of-frame pulse;
//   busy_o sequencer not idle.
module mux_scan_ctrl #(
    parameter int DWELL_WIDTH   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [3:0]             ch_mask_i,
    input  logic                   dc_req_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    output logic [2:0]             sel_o,
    output logic                   sel_valid_o,
    output logic [1:0]             ch_id_o,
    output logic                   frame_done_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DC} state_t;
    localparam logic [2:0] SEL_PARK = 3'b111;
    localparam logic [2:0] SEL_DC = 3'b100;
    // settle and dwell share one down-counter, so SETTLE_CYCLES must fit in DWELL_WIDTH
    localparam logic [DWELL_WIDTH-1:0] SETTLE_LD = DWELL_WIDTH'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    state_t                 state_q, state_d;
    logic [2:0]             sel_q, sel_d, go_sel;
    logic [1:0]             id_q, id_d, low_ch, nxt_ch;
    logic                   valid_q, valid_d, fd_q, fd_d, busy_q;
    logic                   go, park, found;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d, dwell_ld;
    assign dwell_ld = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
    // lowest enabled channel, and the next enabled channel above the current one (wrapping)
    always_comb begin
        low_ch = '0;
        nxt_ch = '0;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (ch_mask_i[i]) low_ch = 2'(i);
            if (ch_mask_i[i] && 2'(i) > id_q) begin
                nxt_ch = 2'(i);
                found = 1'b1;
            end
        end
        if (!found) nxt_ch = low_ch;
    end
    // go: leave for a new target (go_sel) through the blanking window; park: return to IDLE
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        id_d = id_q;
        valid_d = valid_q;
        fd_d = 1'b0;
        cnt_d = cnt_q;
        go = 1'b0;
        go_sel = sel_q;
        park = !en_i;
        if (en_i) begin
            case (state_q)
                IDLE: begin
                    go = dc_req_i || (ch_mask_i != '0);
                    go_sel = dc_req_i ? SEL_DC : {1'b0, low_ch};
                end
                SETTLE: begin
                    cnt_d = (cnt_q == '0) ? dwell_ld : cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = (sel_q == SEL_DC) ? DC : DWELL;
                        valid_d = 1'b1;
                    end
                end
                DWELL: begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    else if (dc_req_i) begin
                        go = 1'b1;
                        go_sel = SEL_DC;
                    end else if (ch_mask_i == '0) park = 1'b1;
                    else begin
                        // a single enabled channel keeps its select and just restarts the dwell
                        fd_d = nxt_ch <= id_q;
                        go = nxt_ch != id_q;
                        go_sel = {1'b0, nxt_ch};
                        cnt_d = dwell_ld;
                    end
                end
                DC: begin
                    go = !dc_req_i && (ch_mask_i != '0);
                    go_sel = {1'b0, low_ch};
                    park = !dc_req_i && (ch_mask_i == '0);
                end
                default: park = 1'b1;
            endcase
        end
        if (park) begin
            state_d = IDLE;
            sel_d = SEL_PARK;
            id_d = '0;
            valid_d = 1'b0;
            fd_d = 1'b0;
        end else if (go) begin
            sel_d = go_sel;
            if (!go_sel[2]) id_d = go_sel[1:0];
            valid_d = SETTLE_CYCLES == 0;
            state_d = (SETTLE_CYCLES == 0) ? (go_sel[2] ? DC : DWELL) : SETTLE;
            cnt_d = (SETTLE_CYCLES == 0) ? dwell_ld : SETTLE_LD;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q <= SEL_PARK;
            id_q <= '0;
            valid_q <= 1'b0;
            fd_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            id_q <= id_d;
            valid_q <= valid_d;
            fd_q <= fd_d;
            busy_q <= state_d != IDLE;
            cnt_q <= cnt_d;
        end
    end
    assign sel_o = sel_q;
    assign sel_valid_o = valid_q;
    assign ch_id_o = id_q;
    assign frame_done_o = fd_q;
    assign busy_o = busy_q;
endmodule
